// File: rtl/idex_pipe_reg.sv
// ---------------------------------------------------------------------------
// idex_pipe_reg
// ID/EX pipeline register for the 5-stage MIPS core. It carries decoded
// control and operand data from decode into execute. It also does the
// following:
//   - keeps a valid bit for the execute stage
//   - holds on an external stall request
//   - turns a flush into a bubble
//   - detects load-use hazards and inserts exactly one bubble for each
//   - counts inserted bubbles in a saturating counter
//
// Ports
//   clk, rst          rising-edge clock, async active-high reset
//   id_*              decode-stage instruction (valid, ctrl, operands, regs)
//   id_uses_rt        decode instruction reads rt as a source
//   stall_in          downstream hold request
//   flush             squash request (taken branch/jump)
//   ex_*              registered execute-stage copy of id_*
//   stall_out         combinational freeze for PC and IF/ID
//   bubble_cnt        saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module idex_pipe_reg #(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int CTRL_W       = 11,
    parameter int MEM_READ_BIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_uses_rt,
    input  logic              stall_in,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              stall_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
    logic [DATA_W-1:0] ex_rd1_q,   ex_rd1_d;
    logic [DATA_W-1:0] ex_rd2_q,   ex_rd2_d;
    logic [DATA_W-1:0] ex_imm_q,   ex_imm_d;
    logic [DATA_W-1:0] ex_pc4_q,   ex_pc4_d;
    logic [REG_W-1:0]  ex_rs_q,    ex_rs_d;
    logic [REG_W-1:0]  ex_rt_q,    ex_rt_d;
    logic [REG_W-1:0]  ex_rd_q,    ex_rd_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic load_use;
    logic bubble;

    // A load in EX whose destination is read by the instruction in ID.
    // A load into $0 is excluded because $0 always reads as zero.
    always_comb begin
        load_use = ex_valid_q & ex_ctrl_q[MEM_READ_BIT] & id_valid &
                   (ex_rt_q != '0) &
                   ((ex_rt_q == id_rs) | (id_uses_rt & (ex_rt_q == id_rt)));
    end

    assign stall_out = stall_in | load_use;

    always_comb begin
        // Default to holding every register.
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_rd1_d   = ex_rd1_q;
        ex_rd2_d   = ex_rd2_q;
        ex_imm_d   = ex_imm_q;
        ex_pc4_d   = ex_pc4_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_rd_d    = ex_rd_q;
        bubble     = 1'b0;

        if (flush || (!stall_in && load_use)) begin
            // This branch covers a flush, which beats a stall, and a load-use
            // bubble when there is no stall. A bubble clears only valid and
            // control. Data is left stale because nothing downstream uses it.
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            bubble     = 1'b1;
        end else if (!stall_in) begin
            ex_valid_d = id_valid;
            ex_ctrl_d  = id_valid ? id_ctrl : '0;
            ex_rd1_d   = id_rd1;
            ex_rd2_d   = id_rd2;
            ex_imm_d   = id_imm;
            ex_pc4_d   = id_pc4;
            ex_rs_d    = id_rs;
            ex_rt_d    = id_rt;
            ex_rd_d    = id_rd;
        end

        cnt_d = cnt_q;
        if (bubble && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_pc4_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd1_q   <= ex_rd1_d;
            ex_rd2_q   <= ex_rd2_d;
            ex_imm_q   <= ex_imm_d;
            ex_pc4_q   <= ex_pc4_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_rd1     = ex_rd1_q;
    assign ex_rd2     = ex_rd2_q;
    assign ex_imm     = ex_imm_q;
    assign ex_pc4     = ex_pc4_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_rd      = ex_rd_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_idex_pipe_reg
// Directed bench for idex_pipe_reg. Two instances share the same inputs:
//   - dut uses the default parameters
//   - dut4 uses a 4-bit bubble counter, for the saturation case
// The bench keeps a reference model of the execute stage and an unbounded
// bubble count. A negedge process compares every output against that model.
// Directed checks with literal values pin the model at key points.
// ---------------------------------------------------------------------------
module tb_idex_pipe_reg;
    localparam int DW = 32, RW = 5, CW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0, id_uses_rt = 1'b0, stall_in = 1'b0, flush = 1'b0;
    logic [CW-1:0] id_ctrl = '0;
    logic [DW-1:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0, id_pc4 = '0;
    logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;

    logic          ex_valid, stall_out;
    logic [CW-1:0] ex_ctrl;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd;
    logic [15:0]   bubble_cnt;

    logic          s_valid, s_stall;
    logic [CW-1:0] s_ctrl;
    logic [DW-1:0] s_rd1, s_rd2, s_imm, s_pc4;
    logic [RW-1:0] s_rs, s_rt, s_rd;
    logic [3:0]    s_cnt;

    always #5 clk = ~clk;

    idex_pipe_reg dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall_out(stall_out),
        .bubble_cnt(bubble_cnt)
    );

    idex_pipe_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .stall_in(stall_in), .flush(flush), .ex_valid(s_valid), .ex_ctrl(s_ctrl),
        .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_pc4(s_pc4),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .stall_out(s_stall),
        .bubble_cnt(s_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The execute stage is modelled as a record of what it holds. The bubble
    // count is unbounded and gets clamped per counter width when compared.
    logic          m_valid;
    logic [CW-1:0] m_ctrl;
    logic [DW-1:0] m_rd1, m_rd2, m_imm, m_pc4;
    logic [RW-1:0] m_rs, m_rt, m_rd;
    int            m_cnt;

    function automatic bit m_hazard();
        // Does the instruction in decode read the register a load in EX writes?
        bit is_load = m_valid && m_ctrl[3];
        bit reads   = (id_rs == m_rt) || (id_uses_rt && id_rt == m_rt);
        return is_load && id_valid && (m_rt != 0) && reads;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc4 = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_cnt = 0;
        end else if (flush || (!stall_in && m_hazard())) begin
            m_valid = 0; m_ctrl = 0; m_cnt = m_cnt + 1;
        end else if (!stall_in) begin
            m_valid = id_valid;
            m_ctrl  = id_valid ? id_ctrl : 0;
            m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm; m_pc4 = id_pc4;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
        end
    end

    always @(negedge clk) begin
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_ctrl", ex_ctrl, m_ctrl);
        chk("ex_rd1", ex_rd1, m_rd1);
        chk("ex_rd2", ex_rd2, m_rd2);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_pc4", ex_pc4, m_pc4);
        chk("ex_rs", ex_rs, m_rs);
        chk("ex_rt", ex_rt, m_rt);
        chk("ex_rd", ex_rd, m_rd);
        chk("stall_out", stall_out, stall_in | m_hazard());
        chk("bubble_cnt16", bubble_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("bubble_cnt4", s_cnt, (m_cnt > 15) ? 15 : m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [RW-1:0] rs,
                         input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                         input logic urt, input logic [DW-1:0] d1);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rt = urt; id_rd1 = d1; id_rd2 = ~d1; id_imm = d1 ^ 32'h0F0F_0F0F;
        id_pc4 = d1 + 32'd4;
    endtask

    initial begin
        // Reset state.
        drive(1, 11'h7FF, 3, 4, 5, 1, 32'h5555_AAAA);
        repeat (2) tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_ctrl", ex_ctrl, 0);
        chk("rst_cnt", bubble_cnt, 0);
        rst = 0;

        // Normal flow.
        drive(1, 11'h155, 1, 5, 9, 1, 32'hDEAD_BEEF);
        tick();
        chk("norm_valid", ex_valid, 1);
        chk("norm_ctrl", ex_ctrl, 11'h155);
        chk("norm_rd1", ex_rd1, 32'hDEAD_BEEF);
        chk("norm_rt", ex_rt, 5);
        drive(0, 11'h7FF, 1, 5, 9, 1, 32'hCAFE_F00D);
        tick();
        chk("inv_valid", ex_valid, 0);
        chk("inv_ctrl", ex_ctrl, 0);
        chk("inv_rd1", ex_rd1, 32'hCAFE_F00D);

        // A single flush counts one bubble.
        flush = 1; tick(); flush = 0;
        chk("flush_cnt", bubble_cnt, 1);

        // Async reset between edges.
        drive(1, 11'h155, 2, 6, 7, 1, 32'h1111_1111);
        tick();
        chk("pre_rst_valid", ex_valid, 1);
        #2 rst = 1;
        #1;
        chk("arst_valid", ex_valid, 0);
        chk("arst_ctrl", ex_ctrl, 0);
        chk("arst_rd1", ex_rd1, 0);
        chk("arst_rt", ex_rt, 0);
        chk("arst_cnt", bubble_cnt, 0);
        chk("arst_cnt4", s_cnt, 0);
        rst = 0;
        tick();
        chk("post_rst_ctrl", ex_ctrl, 11'h155);
        chk("post_rst_rt", ex_rt, 6);

        // Load-use: a load into r8 followed by a reader of r8.
        drive(1, 11'h008, 4, 8, 0, 0, 32'hAAAA_0000);
        tick();
        drive(1, 11'h155, 8, 3, 10, 0, 32'h0000_1234);
        #1 chk("lu_stall", stall_out, 1);
        tick();
        chk("lu_valid", ex_valid, 0);
        chk("lu_ctrl", ex_ctrl, 0);
        chk("lu_hold_rd1", ex_rd1, 32'hAAAA_0000);
        chk("lu_cnt", bubble_cnt, 1);
        #1 chk("lu_release", stall_out, 0);
        tick();
        chk("lu_cap_valid", ex_valid, 1);
        chk("lu_cap_ctrl", ex_ctrl, 11'h155);
        chk("lu_cap_rd1", ex_rd1, 32'h0000_1234);

        // No false hazard: a load into $0, and an rt match without rt use.
        drive(1, 11'h008, 0, 0, 0, 1, 32'h5);
        tick();
        drive(1, 11'h155, 0, 0, 2, 1, 32'h6);
        #1 chk("r0_no_stall", stall_out, 0);
        tick();
        drive(1, 11'h008, 1, 8, 0, 0, 32'h7);
        tick();
        drive(1, 11'h155, 1, 8, 2, 0, 32'h8);
        #1 chk("rt_unused_no_stall", stall_out, 0);
        id_uses_rt = 1;
        #1 chk("rt_used_stall", stall_out, 1);

        // stall_in with load_use: hold without counting, then one bubble.
        stall_in = 1;
        tick();
        chk("sl_ctrl_hold", ex_ctrl, 11'h008);
        chk("sl_cnt", bubble_cnt, 1);
        stall_in = 0;
        tick();
        chk("sl_bubble_valid", ex_valid, 0);
        chk("sl_bubble_cnt", bubble_cnt, 2);
        tick();
        chk("sl_cap_ctrl", ex_ctrl, 11'h155);

        // flush together with stall_in: the flush wins.
        flush = 1; stall_in = 1;
        tick();
        flush = 0; stall_in = 0;
        chk("fs_valid", ex_valid, 0);
        chk("fs_cnt", bubble_cnt, 3);

        // flush together with load_use: only one bubble is counted.
        drive(1, 11'h008, 1, 9, 0, 0, 32'h9);
        tick();
        drive(1, 11'h155, 9, 0, 4, 0, 32'hA);
        flush = 1;
        tick();
        flush = 0;
        chk("fl_cnt", bubble_cnt, 4);
        tick();
        chk("fl_cap_ctrl", ex_ctrl, 11'h155);

        // stall_in alone: hold control and do not count.
        drive(1, 11'h2AA, 1, 2, 3, 1, 32'hB);
        stall_in = 1;
        tick();
        chk("st_ctrl", ex_ctrl, 11'h155);
        chk("st_cnt", bubble_cnt, 4);
        stall_in = 0;

        // Saturation: the 4-bit counter stops at F, the 16-bit one keeps counting.
        flush = 1;
        repeat (17) tick();
        chk("sat4", s_cnt, 4'hF);
        chk("sat16", bubble_cnt, 21);
        tick();
        chk("sat4_hold", s_cnt, 4'hF);
        chk("sat16_inc", bubble_cnt, 22);
        flush = 0;

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
